// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline stage boundaries.
// No logic; widths and the ex_ctrl bit order live only here.
// Consumers import mips_pipe_pkg::*.
package mips_pipe_pkg;

   // ex_ctrl bit positions. There are six control fields, so the word is
   // six bits wide and reg_write sits in the top bit.
   localparam int CTRL_W          = 6;
   localparam int CTRL_BRANCH     = 0;
   localparam int CTRL_BRANCH_NE  = 1;
   localparam int CTRL_MEM_TO_REG = 2;
   localparam int CTRL_MEM_WRITE  = 3;
   localparam int CTRL_MEM_READ   = 4;
   localparam int CTRL_REG_WRITE  = 5;

   // EX/MEM payload: {alu_result, zero, store_data, write_reg, branch_target, ctrl}
   function automatic int ex_mem_pay_w(input int dw, input int rw);
      return 3 * dw + 1 + rw + CTRL_W;
   endfunction

   localparam int EX_MEM_PAY_W = ex_mem_pay_w(32, 5);

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer (output entry + skid entry).
// Latency: 1 cycle from accept to out_valid when the output entry is free.
// Backpressure: in_ready = ~skid_valid, registered; no comb path from out_ready.
module pipe_skid_buffer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         out_valid_q, out_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] out_data_q, out_data_d;
   logic [W-1:0] skid_data_q, skid_data_d;
   logic         accept;

   assign accept    = in_valid & ~skid_valid_q & ~flush;
   assign in_ready  = ~skid_valid_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   // Next state: flush wins, then refill a free output, else park in skid.
   always_comb begin
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      out_data_d   = out_data_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (~out_valid_q | out_ready) begin
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_data_d  = in_data;
         skid_valid_d = 1'b1;
      end
   end

   // State registers, cleared immediately on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_data_q   <= '0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         out_data_q   <= out_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: skid-buffered payload, branch resolve, EX/MEM forward.
// Latency: 1 cycle from accepted EX beat to mem_valid.
// Backpressure: ex_ready is registered (skid empty); MEM stalls never reach EX combinationally.
module ex_mem_stage
   import mips_pipe_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      ex_valid,
   output logic                      ex_ready,
   input  logic [DATA_WIDTH-1:0]     ex_alu_result,
   input  logic                      ex_zero,
   input  logic [DATA_WIDTH-1:0]     ex_store_data,
   input  logic [REG_ADDR_WIDTH-1:0] ex_write_reg,
   input  logic [DATA_WIDTH-1:0]     ex_branch_target,
   input  logic [CTRL_W-1:0]         ex_ctrl,
   output logic                      mem_valid,
   input  logic                      mem_ready,
   output logic [DATA_WIDTH-1:0]     mem_alu_result,
   output logic                      mem_zero,
   output logic [DATA_WIDTH-1:0]     mem_store_data,
   output logic [REG_ADDR_WIDTH-1:0] mem_write_reg,
   output logic [DATA_WIDTH-1:0]     mem_branch_target,
   output logic [CTRL_W-1:0]         mem_ctrl,
   output logic                      mem_pc_src,
   output logic                      fwd_en,
   output logic [REG_ADDR_WIDTH-1:0] fwd_reg,
   output logic [DATA_WIDTH-1:0]     fwd_value
);

   localparam int PAY_W = ex_mem_pay_w(DATA_WIDTH, REG_ADDR_WIDTH);

   logic [PAY_W-1:0] in_pay;
   logic [PAY_W-1:0] out_pay;

   assign in_pay = {ex_alu_result, ex_zero, ex_store_data, ex_write_reg,
                    ex_branch_target, ex_ctrl};

   pipe_skid_buffer #(.W(PAY_W)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (ex_valid),
      .in_ready  (ex_ready),
      .in_data   (in_pay),
      .out_valid (mem_valid),
      .out_ready (mem_ready),
      .out_data  (out_pay)
   );

   assign {mem_alu_result, mem_zero, mem_store_data, mem_write_reg,
           mem_branch_target, mem_ctrl} = out_pay;

   // BEQ takes on Zero, BNE on ~Zero; only a valid output entry can redirect.
   assign mem_pc_src = mem_valid &
                       ((mem_ctrl[CTRL_BRANCH] & mem_zero) |
                        (mem_ctrl[CTRL_BRANCH_NE] & ~mem_zero));

   // $0 is hardwired zero, so it is never a forwarding source.
   assign fwd_en    = mem_valid & mem_ctrl[CTRL_REG_WRITE] & (mem_write_reg != '0);
   assign fwd_reg   = mem_write_reg;
   assign fwd_value = mem_alu_result;

   // A load and a store in one beat is a decoder bug upstream; passed through, only flagged.
   a_rd_wr_excl: assert property (@(posedge clk) disable iff (reset)
      mem_valid |-> !(mem_ctrl[CTRL_MEM_READ] && mem_ctrl[CTRL_MEM_WRITE]));

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;
   import mips_pipe_pkg::*;

   typedef struct packed {
      logic [31:0]       alu;
      logic              z;
      logic [31:0]       sd;
      logic [4:0]        wr;
      logic [31:0]       bt;
      logic [CTRL_W-1:0] ctrl;
   } beat_t;

   logic              clk, reset, flush, ex_valid, ex_ready;
   logic [31:0]       ex_alu_result, ex_store_data, ex_branch_target;
   logic              ex_zero;
   logic [4:0]        ex_write_reg;
   logic [CTRL_W-1:0] ex_ctrl;
   logic              mem_valid, mem_ready, mem_zero, mem_pc_src, fwd_en;
   logic [31:0]       mem_alu_result, mem_store_data, mem_branch_target, fwd_value;
   logic [4:0]        mem_write_reg, fwd_reg;
   logic [CTRL_W-1:0] mem_ctrl;

   int  nvec = 0;
   int  nerr = 0;
   bit  run_cmp = 0;
   bit  last_acc;
   beat_t mq[$];

   ex_mem_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_alu_result(ex_alu_result), .ex_zero(ex_zero), .ex_store_data(ex_store_data),
      .ex_write_reg(ex_write_reg), .ex_branch_target(ex_branch_target), .ex_ctrl(ex_ctrl),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_alu_result(mem_alu_result), .mem_zero(mem_zero), .mem_store_data(mem_store_data),
      .mem_write_reg(mem_write_reg), .mem_branch_target(mem_branch_target), .mem_ctrl(mem_ctrl),
      .mem_pc_src(mem_pc_src), .fwd_en(fwd_en), .fwd_reg(fwd_reg), .fwd_value(fwd_value)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the stage is a FIFO of depth 2; EX may push while fewer than two are held.
   always @(posedge clk or posedge reset) begin : model
      int    sz;
      beat_t b;
      if (reset || flush) begin
         mq.delete();
      end else begin
         sz = mq.size();
         b.alu = ex_alu_result; b.z = ex_zero; b.sd = ex_store_data;
         b.wr = ex_write_reg; b.bt = ex_branch_target; b.ctrl = ex_ctrl;
         if (sz > 0 && mem_ready) void'(mq.pop_front());
         if (ex_valid && sz < 2) mq.push_back(b);
      end
   end

   // Every cycle: compare DUT outputs with the FIFO head.
   always @(negedge clk) begin : compare
      beat_t e, a;
      if (run_cmp && !reset) begin
         chk("mem_valid", mem_valid, mq.size() > 0);
         chk("ex_ready", ex_ready, mq.size() < 2);
         if (mq.size() > 0) begin
            e = mq[0];
            a.alu = mem_alu_result; a.z = mem_zero; a.sd = mem_store_data;
            a.wr = mem_write_reg; a.bt = mem_branch_target; a.ctrl = mem_ctrl;
            chk("payload", a, e);
            chk("pc_src", mem_pc_src,
                (e.ctrl[CTRL_BRANCH] && e.z) || (e.ctrl[CTRL_BRANCH_NE] && !e.z));
            chk("fwd_en", fwd_en, e.ctrl[CTRL_REG_WRITE] && e.wr != 0);
            chk("fwd_reg", fwd_reg, e.wr);
            chk("fwd_value", fwd_value, e.alu);
         end else begin
            chk("pc_src_idle", mem_pc_src, 1'b0);
            chk("fwd_en_idle", fwd_en, 1'b0);
         end
      end
   end

   function automatic beat_t mk(input logic [31:0] alu, input logic z, input logic [4:0] wr,
                                input logic [31:0] bt, input logic [CTRL_W-1:0] ctrl);
      beat_t b;
      b.alu = alu; b.z = z; b.sd = $urandom; b.wr = wr; b.bt = bt; b.ctrl = ctrl;
      return b;
   endfunction

   function automatic beat_t rnd();
      logic [CTRL_W-1:0] c;
      c = CTRL_W'($urandom);
      if (c[CTRL_MEM_READ] && c[CTRL_MEM_WRITE]) c[CTRL_MEM_WRITE] = 1'b0;
      return mk($urandom, 1'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                $urandom, c);
   endfunction

   // Present inputs just after an edge, record acceptance, advance to just after the next edge.
   task automatic drive(input bit v, input beat_t b, input bit mr, input bit fl);
      ex_valid = v; ex_alu_result = b.alu; ex_zero = b.z; ex_store_data = b.sd;
      ex_write_reg = b.wr; ex_branch_target = b.bt; ex_ctrl = b.ctrl;
      mem_ready = mr; flush = fl;
      #3 last_acc = ex_valid && ex_ready && !flush;
      @(posedge clk); #1;
   endtask

   initial begin : stim
      beat_t cur, x;
      bit    cv, mr, fl;
      logic [CTRL_W-1:0] c;
      reset = 1; flush = 0; ex_valid = 0; mem_ready = 0;
      ex_alu_result = 0; ex_zero = 0; ex_store_data = 0; ex_write_reg = 0;
      ex_branch_target = 0; ex_ctrl = 0;
      #2;
      chk("rst_mem_valid", mem_valid, 1'b0);
      chk("rst_ex_ready", ex_ready, 1'b1);
      chk("rst_fwd_en", fwd_en, 1'b0);
      chk("rst_pc_src", mem_pc_src, 1'b0);
      chk("rst_alu", mem_alu_result, 32'h0);
      @(posedge clk); #1;
      reset = 0;
      run_cmp = 1;

      // Streaming with MEM always ready.
      drive(1, mk(32'h00000005, 0, 5'd1, 0, '0), 1, 0);
      chk("s0_alu", mem_alu_result, 32'h00000005);
      drive(1, mk(32'h0000000A, 0, 5'd2, 0, '0), 1, 0);
      chk("s1_alu", mem_alu_result, 32'h0000000A);
      chk("s1_rdy", ex_ready, 1'b1);
      drive(1, mk(32'hFFFFFFFF, 0, 5'd3, 0, '0), 1, 0);
      chk("s2_alu", mem_alu_result, 32'hFFFFFFFF);
      chk("s2_rdy", ex_ready, 1'b1);
      drive(0, mk(0, 0, 0, 0, '0), 1, 0);
      chk("s3_valid", mem_valid, 1'b0);

      // MEM stall with A, B, C.
      drive(1, mk(32'hA, 0, 5'd4, 0, '0), 0, 0);
      chk("st_a", mem_alu_result, 32'hA);
      x = mk(32'hC, 0, 5'd6, 0, '0);
      drive(1, mk(32'hB, 0, 5'd5, 0, '0), 0, 0);
      chk("st_full_rdy", ex_ready, 1'b0);
      drive(1, x, 0, 0);
      chk("st_hold_a", mem_alu_result, 32'hA);
      drive(1, x, 1, 0);
      chk("st_b", mem_alu_result, 32'hB);
      drive(1, x, 1, 0);
      chk("st_c", mem_alu_result, 32'hC);
      drive(0, x, 1, 0);

      // Branch resolution.
      c = '0; c[CTRL_BRANCH] = 1'b1;
      drive(1, mk(32'h0, 1, 5'd0, 32'h00400020, c), 1, 0);
      chk("beq_taken", mem_pc_src, 1'b1);
      chk("beq_target", mem_branch_target, 32'h00400020);
      c = '0; c[CTRL_BRANCH_NE] = 1'b1;
      drive(1, mk(32'h0, 1, 5'd0, 32'h00400040, c), 1, 0);
      chk("bne_not_taken", mem_pc_src, 1'b0);

      // Flush with both entries full and EX presenting.
      drive(1, mk(32'h111, 0, 5'd7, 0, '0), 0, 0);
      drive(1, mk(32'h222, 0, 5'd7, 0, '0), 0, 0);
      drive(1, mk(32'h333, 0, 5'd7, 0, '0), 0, 1);
      chk("fl_valid", mem_valid, 1'b0);
      chk("fl_rdy", ex_ready, 1'b1);
      drive(0, x, 1, 0);
      chk("fl_gone", mem_valid, 1'b0);

      // Forwarding, including the $0 exclusion.
      c = '0; c[CTRL_REG_WRITE] = 1'b1;
      drive(1, mk(32'h1234, 0, 5'd0, 0, c), 1, 0);
      chk("fwd_r0", fwd_en, 1'b0);
      drive(1, mk(32'h1234, 0, 5'd8, 0, c), 1, 0);
      chk("fwd_r8_en", fwd_en, 1'b1);
      chk("fwd_r8_reg", fwd_reg, 5'd8);
      chk("fwd_r8_val", fwd_value, 32'h1234);

      // Random traffic; EX holds a beat until accepted.
      cv = 0; cur = rnd(); last_acc = 1;
      for (int i = 0; i < 3000; i++) begin
         if (!cv || last_acc || fl) begin
            cv  = ($urandom_range(0, 3) != 0);
            cur = rnd();
         end
         mr = ($urandom_range(0, 9) < 7);
         fl = ($urandom_range(0, 49) == 0);
         drive(cv, cur, mr, fl);
      end

      // Asynchronous reset with both entries full.
      drive(1, rnd(), 0, 0);
      drive(1, rnd(), 0, 0);
      drive(1, rnd(), 0, 0);
      chk("pre_rst_valid", mem_valid, 1'b1);
      chk("pre_rst_rdy", ex_ready, 1'b0);
      ex_valid = 0;
      #2 reset = 1;
      #1;
      chk("mid_rst_valid", mem_valid, 1'b0);
      chk("mid_rst_rdy", ex_ready, 1'b1);
      chk("mid_rst_fwd", fwd_en, 1'b0);
      chk("mid_rst_pc", mem_pc_src, 1'b0);
      @(posedge clk); #1;
      reset = 0;
      drive(1, rnd(), 1, 0);
      drive(0, rnd(), 1, 0);
      drive(0, rnd(), 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
